upower_fetch_unit: RTL and testbench

//   Instruction-fetch front end of the uPower core. Owns the word-addressed PC,

---
 rtl/upower_pkg.sv | 19 +
 rtl/upower_fetch_queue.sv | 56 +++++
 rtl/upower_fetch_unit.sv | 121 ++++++++++++
 tb/tb_upower_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upower_pkg.sv
// Shared constants and types for the uPower instruction-fetch front end.
package upower_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  // One decoded-side queue entry: the fetched word and the address it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

  // RUN: responses go to the queue. SQUASH: responses belong to a dead path.
  typedef enum logic {
    FETCH_RUN    = 1'b0,
    FETCH_SQUASH = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/upower_fetch_queue.sv
// Small synchronous FIFO with flush and occupancy count. The head entry is read
// straight out of the storage registers, so it is stable while nothing pops.
module upower_fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop frees a slot in the same cycle, so push+pop on a full FIFO is legal.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping; flush empties the FIFO outright.
  always_ff @(posedge clock) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage array; no reset needed since count gates every read.
  always_ff @(posedge clock) begin
    if (do_push && !flush_i && !reset) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/upower_fetch_unit.sv
// uPower fetch front end: PC, credit-limited request issue, in-order response
// capture, decode-side queue, and redirect handling with wrong-path squashing.
module upower_fetch_unit #(
  parameter int              QDEPTH   = 2,
  parameter int              PC_W     = upower_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [31:0]     dec_instr,
  output logic [PC_W-1:0] dec_pc,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc
);
  import upower_pkg::*;

  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int ENT_W = INSTR_W + PC_W;

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] inflight;       // occupancy of the pc-tag FIFO
  logic [CNT_W-1:0] inflight_next;
  logic [CNT_W-1:0] iq_count;
  logic [CNT_W:0]   credit_used;
  logic [PC_W-1:0]  tag_rdata;
  logic [ENT_W-1:0] iq_rdata;
  logic             req_fire, rsp_take, dec_fire;
  logic             iq_push, iq_pop, iq_flush;

  // A request is only issued if its response is guaranteed a queue slot.
  assign credit_used    = {1'b0, iq_count} + {1'b0, inflight};
  assign imem_req_valid = !reset && (credit_used < (CNT_W + 1)'(QDEPTH));
  assign imem_req_addr  = pc_q;

  assign req_fire      = imem_req_valid && imem_req_ready;
  assign rsp_take      = imem_rsp_valid && !reset;
  assign dec_valid     = !reset && (iq_count != '0);
  assign dec_fire      = dec_valid && dec_ready;
  assign {dec_instr, dec_pc} = iq_rdata;
  assign inflight_next = inflight + CNT_W'(req_fire) - CNT_W'(rsp_take);

  // Outstanding-request tags; never flushed because memory still answers them.
  upower_fetch_queue #(.DEPTH(QDEPTH), .WIDTH(PC_W)) u_tag_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush_i (1'b0),
    .push_i  (req_fire),
    .wdata_i (pc_q),
    .pop_i   (rsp_take),
    .rdata_o (tag_rdata),
    .count_o (inflight)
  );

  // Instruction queue feeding decode.
  upower_fetch_queue #(.DEPTH(QDEPTH), .WIDTH(ENT_W)) u_instr_queue (
    .clock   (clock),
    .reset   (reset),
    .flush_i (iq_flush),
    .push_i  (iq_push),
    .wdata_i ({imem_rsp_data, tag_rdata}),
    .pop_i   (iq_pop),
    .rdata_o (iq_rdata),
    .count_o (iq_count)
  );

  // Next PC, drop count, queue control and RUN/SQUASH transition; redirect wins.
  always_comb begin
    pc_d     = pc_q;
    drop_d   = drop_q;
    state_d  = state_q;
    iq_push  = 1'b0;
    iq_pop   = 1'b0;
    iq_flush = 1'b0;
    if (redirect_valid) begin
      // Everything still outstanding after this edge belongs to the old path.
      pc_d     = redirect_pc;
      drop_d   = inflight_next;
      iq_flush = 1'b1;
    end else begin
      if (req_fire) pc_d = pc_q + 1'b1;
      iq_pop = dec_fire;
      if (rsp_take) begin
        if (state_q == FETCH_SQUASH) drop_d = drop_q - 1'b1;
        else                         iq_push = 1'b1;
      end
    end
    case (state_q)
      FETCH_RUN:    if (drop_d != '0) state_d = FETCH_SQUASH;
      FETCH_SQUASH: if (drop_d == '0) state_d = FETCH_RUN;
    endcase
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      drop_q  <= '0;
      state_q <= FETCH_RUN;
    end else begin
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      state_q <= state_d;
    end
  end

  a_rsp_without_request: assert property (@(posedge clock) disable iff (reset)
    !(imem_rsp_valid && (inflight == '0)));

  a_queue_overflow: assert property (@(posedge clock) disable iff (reset)
    !(iq_push && !iq_pop && (iq_count == CNT_W'(QDEPTH))));

endmodule

// File: tb/tb_upower_fetch_unit.sv
// Bench for upower_fetch_unit: a variable-latency in-order memory model, a
// program-order reference of what decode and memory must see, and directed
// scenarios (stall, redirects, mid-stream reset, PC wrap on a second instance).
module tb_upower_fetch_unit;
  import upower_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data  = 32'h0;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_instr, dec_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data  = 32'h0;
  logic        w_dec_valid;
  logic [31:0] w_dec_instr, w_dec_pc;

  int vectors    = 0;
  int miscompares = 0;

  upower_fetch_unit #(.QDEPTH(2), .PC_W(32), .RESET_PC(32'h0)) u_dut (
    .clock(clk), .reset(reset),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  upower_fetch_unit #(.QDEPTH(2), .PC_W(32), .RESET_PC(32'hFFFF_FFFE)) u_wrap (
    .clock(clk), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .dec_valid(w_dec_valid), .dec_ready(1'b1), .dec_instr(w_dec_instr), .dec_pc(w_dec_pc),
    .redirect_valid(1'b0), .redirect_pc(32'h0)
  );

  // Contents of instruction memory at any word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h, want %08h", name, act, exp);
    end
  endtask

  // ---------------- memory model: in order, fixed latency 'lat' ----------------
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;
  mreq_t       mq[$];
  int unsigned cyc = 0;
  int unsigned lat = 1;

  always @(posedge clk) begin
    mreq_t e;
    cyc++;
    if (reset) begin
      mq.delete();
    end else begin
      if (rsp_valid) void'(mq.pop_front());
      if (req_valid && req_ready) begin
        e.addr = req_addr;
        e.due  = cyc + lat - 1;
        mq.push_back(e);
      end
    end
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = mem_word(mq[0].addr);
    end else begin
      rsp_valid = 1'b0;
    end
  end

  // One-cycle memory for the wrap-around instance (always ready).
  always @(posedge clk) begin
    logic        f2;
    logic [31:0] a2;
    f2 = w_req_valid;
    a2 = w_req_addr;
    #1;
    w_rsp_valid = f2;
    w_rsp_data  = mem_word(a2);
  end

  // ---------------- reference: program order with redirects ----------------
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] req_exp = 32'h0;
  logic        stall_prev = 1'b0, redir_prev = 1'b0, reset_prev = 1'b0;
  logic [31:0] stall_pc = 32'h0, stall_instr = 32'h0;
  logic [31:0] last_dec_pc = 32'h0;
  int          ndec = 0;

  always @(negedge clk) begin
    if (reset) begin
      chk("reset_req_valid", 32'(req_valid), 32'd0);
      chk("reset_dec_valid", 32'(dec_valid), 32'd0);
      exp_pc     = 32'h0;
      req_exp    = 32'h0;
      stall_prev = 1'b0;
      redir_prev = 1'b0;
      reset_prev = 1'b1;
    end else begin
      if (reset_prev) begin
        chk("post_reset_req_valid", 32'(req_valid), 32'd1);
        chk("post_reset_dec_valid", 32'(dec_valid), 32'd0);
      end
      if (redir_prev) chk("flush_dec_valid", 32'(dec_valid), 32'd0);
      if (stall_prev) begin
        chk("stall_hold_valid", 32'(dec_valid), 32'd1);
        chk("stall_hold_pc", dec_pc, stall_pc);
        chk("stall_hold_instr", dec_instr, stall_instr);
      end
      chk("inflight_bound", 32'(mq.size() <= 2), 32'd1);
      if (req_valid && req_ready) begin
        chk("req_addr", req_addr, req_exp);
        req_exp++;
      end
      if (dec_valid) begin
        chk("dec_pc", dec_pc, exp_pc);
        chk("dec_instr", dec_instr, mem_word(dec_pc));
      end
      if (redirect_valid) begin
        exp_pc     = redirect_pc;
        req_exp    = redirect_pc;
        stall_prev = 1'b0;
        redir_prev = 1'b1;
      end else begin
        redir_prev = 1'b0;
        if (dec_valid && dec_ready) begin
          $display("dec  pc=%08h instr=%08h", dec_pc, dec_instr);
          ndec++;
          last_dec_pc = dec_pc;
          exp_pc++;
        end
        stall_prev  = dec_valid && !dec_ready;
        stall_pc    = dec_pc;
        stall_instr = dec_instr;
      end
      reset_prev = 1'b0;
    end
  end

  // Record the first transactions of the wrap-around instance after reset.
  logic [31:0]  w_addr[4];
  fetch_entry_t w_ent[4];
  int w_na = 0, w_nd = 0;
  always @(negedge clk) begin
    if (!reset && w_req_valid && w_na < 4) begin
      w_addr[w_na] = w_req_addr;
      w_na++;
    end
    if (!reset && w_dec_valid && w_nd < 4) begin
      w_ent[w_nd].instr = w_dec_instr;
      w_ent[w_nd].pc    = w_dec_pc;
      w_nd++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_dec(input int n, input int budget);
    int start;
    int k;
    start = ndec;
    k = 0;
    while (ndec < start + n && k < budget) begin
      step(1);
      k++;
    end
    chk("wait_dec_budget", 32'(ndec - start >= n), 32'd1);
  endtask

  task automatic wait_inflight2(input int budget);
    int k;
    k = 0;
    while (mq.size() != 2 && k < budget) begin
      step(1);
      k++;
    end
    chk("two_inflight", 32'(mq.size()), 32'd2);
  endtask

  initial begin
    logic [31:0] w_exp[4];
    int k;
    w_exp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    reset = 1'b1; req_ready = 1'b1; dec_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(3);
    reset = 1'b0;

    // 1: straight-line fetch from 0 with 1-cycle memory.
    wait_dec(8, 40);
    chk("t1_last_pc", last_dec_pc, 32'h7);

    // 2: decode stalls; queue fills, requests stop, order resumes intact.
    dec_ready = 1'b0;
    step(10);
    chk("t2_dec_valid", 32'(dec_valid), 32'd1);
    chk("t2_req_valid", 32'(req_valid), 32'd0);
    chk("t2_head_pc", dec_pc, 32'h8);
    dec_ready = 1'b1;
    wait_dec(4, 40);
    chk("t2_last_pc", last_dec_pc, 32'hB);

    // 3: latency 3, redirect to 0x40 with two requests outstanding.
    lat = 3;
    wait_inflight2(30);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step(1);
    redirect_valid = 1'b0;
    wait_dec(1, 40);
    chk("t3_first_pc", last_dec_pc, 32'h40);
    wait_dec(3, 40);
    chk("t3_last_pc", last_dec_pc, 32'h43);

    // 4: redirect in a cycle that also has a response and a request handshake.
    lat = 1;
    k = 0;
    while (!(rsp_valid && req_valid && req_ready) && k < 30) begin
      step(1);
      k++;
    end
    chk("t4_collision", 32'(rsp_valid && req_valid && req_ready), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step(1);
    redirect_valid = 1'b0;
    wait_dec(1, 40);
    chk("t4_first_pc", last_dec_pc, 32'h80);
    wait_dec(3, 40);
    chk("t4_last_pc", last_dec_pc, 32'h83);

    // 6a: reset with a full queue.
    dec_ready = 1'b0;
    step(8);
    chk("t6_full_req_valid", 32'(req_valid), 32'd0);
    reset = 1'b1;
    #1;
    chk("t6_rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("t6_rst_req_valid", 32'(req_valid), 32'd0);
    step(1);
    reset = 1'b0; dec_ready = 1'b1;
    #1;
    chk("t6_restart_addr", req_addr, 32'h0);
    wait_dec(3, 40);
    chk("t6_last_pc", last_dec_pc, 32'h2);

    // 6b: reset with two requests outstanding.
    lat = 3;
    wait_inflight2(30);
    reset = 1'b1;
    step(1);
    reset = 1'b0; lat = 1;
    wait_dec(2, 40);
    chk("t6b_last_pc", last_dec_pc, 32'h1);

    // 5: wrap-around instance started at FFFF_FFFE.
    chk("t5_req_count", 32'(w_na), 32'd4);
    chk("t5_dec_count", 32'(w_nd), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_req_addr%0d", i), w_addr[i], w_exp[i]);
      chk($sformatf("t5_dec_pc%0d", i), w_ent[i].pc, w_exp[i]);
      chk($sformatf("t5_dec_instr%0d", i), w_ent[i].instr, mem_word(w_exp[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
